// File: rtl/axi_skid_slice.sv
// axi_skid_slice: two-entry valid/ready register slice with fully registered outputs.
// A main register drives data_o; a skid register absorbs the beat accepted on the
// edge where downstream stalls. ready_o comes straight from a flop, which breaks
// the combinational ready path between the two sides.
// Optional feature macro: AXI_SKID_BEAT_CNT_EN adds a 16-bit wrapping output
// beat counter on beat_cnt_o.
module axi_skid_slice #(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              aclk_i,
    input  logic              aresetn_i,
    input  logic              valid_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DWIDTH-1:0] data_o,
`ifdef AXI_SKID_BEAT_CNT_EN
    output logic [15:0]       beat_cnt_o,
`endif
    input  logic              ready_i
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [DWIDTH-1:0] skid_q, skid_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = valid_i && ready_q;
    assign out_xfer = valid_q && ready_i;

    // Next-state and payload routing between upstream, main and skid registers.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StBusy;
                    data_d  = data_i;
                end
            end
            StBusy: begin
                if (in_xfer && out_xfer) begin
                    data_d = data_i;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new beat, keep data_o stable.
                    state_d = StFull;
                    skid_d  = data_i;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // ready_o is low here, so only the output side can move.
                if (out_xfer) begin
                    state_d = StBusy;
                    data_d  = skid_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
        ready_d = (state_d != StFull);
        valid_d = (state_d != StEmpty);
    end

    // All slice state, cleared asynchronously; ready_q stays low until the first edge.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= StEmpty;
            data_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef AXI_SKID_BEAT_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    // Count output transfers; natural 16-bit wrap.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_xfer) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    // Beat counter register.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`endif

endmodule

// File: doc/axi_skid_slice.md
AXI_SKID_SLICE -- requirements
Module: axi_skid_slice

Interface
REQ-001 Parameter DWIDTH, default 8, payload width in bits; SHALL be >= 1.
REQ-002 Port aclk_i  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 Port aresetn_i  input  1  reset, asynchronous, active-low.
REQ-004 Port valid_i  input  1  upstream beat valid.
REQ-005 Port data_i  input  DWIDTH  upstream payload.
REQ-006 Port ready_o  output  1  upstream ready; SHALL be driven directly by a flop (no combinational path from ready_i).
REQ-007 Port valid_o  output  1  downstream beat valid; driven by a flop.
REQ-008 Port data_o  output  DWIDTH  downstream payload; driven by a flop.
REQ-009 Port ready_i  input  1  downstream ready.

Function
REQ-010 Input transfer SHALL occur on a rising edge where valid_i && ready_o; output transfer where valid_o && ready_i.
REQ-011 Block SHALL hold 0..2 beats: main register (drives data_o) and skid register.
REQ-012 FSM states SHALL be EMPTY (0 beats), BUSY (main only), FULL (main + skid).
REQ-013 EMPTY: input transfer -> BUSY, data_o <= data_i, valid_o <= 1; else stay.
REQ-014 BUSY: input and output together -> stay BUSY, data_o <= data_i.
REQ-015 BUSY: input only -> FULL, skid <= data_i, data_o unchanged.
REQ-016 BUSY: output only -> EMPTY, valid_o <= 0, data_o unchanged.
REQ-017 FULL: output transfer -> BUSY, data_o <= skid; input transfer SHALL NOT occur (ready_o = 0).
REQ-018 ready_o SHALL be registered as (next state != FULL); valid_o SHALL equal (state != EMPTY).
REQ-019 Latency: accepted beat SHALL appear on valid_o/data_o on the next rising edge when block was EMPTY or BUSY-with-output-transfer.
REQ-020 Sustained throughput SHALL be one beat per cycle when ready_i stays high.
REQ-021 Beats SHALL leave in acceptance order; none dropped or duplicated.
REQ-022 While valid_o && !ready_i, data_o and valid_o SHALL remain stable.
REQ-023 Payload SHALL pass unmodified (no arithmetic on data).
REQ-024 valid_i asserted while ready_o = 0 SHALL have no effect; upstream must hold it.

Reset
REQ-025 aresetn_i low SHALL immediately force state EMPTY, valid_o = 0, ready_o = 0, data_o = 0, skid = 0, regardless of clock.
REQ-026 On first rising edge after aresetn_i rises, ready_o SHALL become 1; no transfer SHALL be accepted on that edge.
REQ-027 Reset mid-operation SHALL discard all held beats.

Configuration
REQ-028 Macro AXI_SKID_BEAT_CNT_EN: when defined, output beat_cnt_o (16 bits) SHALL exist and increment by 1 on every output transfer, wrap 0xFFFF -> 0x0000, reset to 0.
REQ-029 When AXI_SKID_BEAT_CNT_EN is undefined, beat_cnt_o and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset: aresetn_i low mid-clock -> valid_o=0, ready_o=0, data_o=0 same instant; one edge after release ready_o=1.
REQ-031 Streaming: ready_i=1, inputs 0x01..0x10 back-to-back -> outputs 0x01..0x10, one per cycle, 1-cycle latency, ready_o never drops.
REQ-032 Backpressure: send 0xA5, 0x5A with ready_i=0 -> state FULL, ready_o=0, data_o=0xA5 stable; raise ready_i -> 0xA5 then 0x5A out, ready_o=1 again.
REQ-033 Random valid_i/ready_i, 10000 beats -> scoreboard order match, no loss, data_o stable while stalled.
REQ-034 Reset while FULL (0x11, 0x22 held) -> both discarded, after release no output until new input.
REQ-035 With AXI_SKID_BEAT_CNT_EN: 65537 output transfers -> beat_cnt_o = 0x0001 after wrap.
